// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared state encoding and default payload field offsets for
//               the generic inter-stage register pipe_stage_buf.
//               Layouts pack fields MSB-first, with the write enable in bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of a pipeline stage buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // F/D layout: instr | PC8 (64 bits)
  localparam int unsigned FD_PC8_LSB   = 0;
  localparam int unsigned FD_INSTR_LSB = 32;
  localparam int unsigned FD_WIDTH     = 64;

  // E/M layout: instr | PC8 | rt_data | ALU_result | write number | write enable
  localparam int unsigned EM_WE_BIT    = 0;
  localparam int unsigned EM_WN_LSB    = 1;
  localparam int unsigned EM_ALU_LSB   = 6;
  localparam int unsigned EM_RT_LSB    = 38;
  localparam int unsigned EM_PC8_LSB   = 70;
  localparam int unsigned EM_INSTR_LSB = 102;
  localparam int unsigned EM_WIDTH     = 134;

  // M/W layout: instr | PC8 | result | write number | write enable
  localparam int unsigned MW_WE_BIT    = 0;
  localparam int unsigned MW_WN_LSB    = 1;
  localparam int unsigned MW_RES_LSB   = 6;
  localparam int unsigned MW_PC8_LSB   = 38;
  localparam int unsigned MW_INSTR_LSB = 70;
  localparam int unsigned MW_WIDTH     = 102;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value. Generic
//               performance counter building block.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset, clears count
//               inc   - count this cycle
//               count - current value, saturates at 2^CNT_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Generic pipeline stage register with valid/ready handshake,
//               optional 2-entry skid buffer, synchronous flush and a
//               saturating back-pressure (stall) counter.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               flush     - synchronous clear of all entries (highest priority)
//               in_valid  - upstream offers in_data
//               in_ready  - stage accepts in_data this cycle
//               in_data   - upstream payload
//               out_valid - out_data holds a valid item
//               out_ready - downstream consumes this cycle
//               out_data  - head payload, zero when out_valid is low
//               stall_cnt - cycles with out_valid & !out_ready, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 134,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // r_in_ready mirrors (next state != FULL). It is only observed in skid
  // mode; in stall mode FULL is unreachable because in_ready already
  // requires out_ready while an item is held, so push implies pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      // A concurrent pop has already been seen downstream; a concurrent
      // push is simply dropped.
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_main  <= in_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_main <= in_data;
          end else if (w_push) begin
            r_skid     <= in_data;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            // Zero the head so an empty stage emits a nop bubble.
            r_main  <= '0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_skid     <= '0;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_main     <= '0;
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: no combinational path from out_ready.
      assign in_ready = r_in_ready;
    end else begin : g_stall
      assign in_ready = ~w_out_valid | out_ready;
    end
  endgenerate

  assign out_valid = w_out_valid;
  assign out_data  = r_main;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Self-checking bench for pipe_stage_buf. Three instances share
//               one stimulus stream: default (skid, 134-bit), stall-register
//               mode (SKID=0) and a 3-bit stall counter. Each is compared
//               against a queue model of its occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [133:0] in_data;
  logic         out_ready;

  logic         in_ready_m, out_valid_m;
  logic [133:0] out_data_m;
  logic [15:0]  stall_cnt_m;

  logic         in_ready_n, out_valid_n;
  logic [7:0]   out_data_n;
  logic [15:0]  stall_cnt_n;

  logic         in_ready_s, out_valid_s;
  logic [7:0]   out_data_s;
  logic [2:0]   stall_cnt_s;

  // Reference model state: items held by each stage, oldest first.
  logic [133:0] q_m[$];
  logic [7:0]   q_n[$];
  logic [15:0]  stall_m, stall_n;
  logic [2:0]   stall_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(134), .SKID(1), .CNT_W(16)) dut_m (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .stall_cnt(stall_cnt_m)
  );

  pipe_stage_buf #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut_n (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data[7:0]),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .stall_cnt(stall_cnt_n)
  );

  pipe_stage_buf #(.WIDTH(8), .SKID(1), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data[7:0]),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue side: record what each stage accepts on this edge.
  always @(posedge clk) begin
    if (reset) begin
      if (flush) begin
        q_m.delete();
        q_n.delete();
      end else begin
        if (in_valid && in_ready_m) q_m.push_back(in_data);
        if (in_valid && in_ready_n) q_n.push_back(in_data[7:0]);
      end
    end
  end

  // Monitor: mid-cycle, compare outputs with the model and retire pops.
  always @(negedge clk) begin
    if (!reset) begin
      q_m.delete();
      q_n.delete();
      stall_m = '0;
      stall_n = '0;
      stall_s = '0;
      chk("rst_out_valid", out_valid_m, 1'b0);
      chk("rst_out_data", out_data_m, '0);
      chk("rst_in_ready", in_ready_m, 1'b1);
      chk("rst_in_ready_n", in_ready_n, 1'b1);
      chk("rst_stall_cnt", stall_cnt_m, '0);
    end else begin
      chk("m_out_valid", out_valid_m, q_m.size() != 0);
      chk("m_in_ready", in_ready_m, q_m.size() < 2);
      chk("m_stall_cnt", stall_cnt_m, stall_m);
      chk("s_out_valid", out_valid_s, q_m.size() != 0);
      chk("s_in_ready", in_ready_s, q_m.size() < 2);
      chk("s_stall_cnt", stall_cnt_s, stall_s);
      if (q_m.size() != 0) begin
        chk("m_out_data", out_data_m, q_m[0]);
        chk("s_out_data", out_data_s, q_m[0][7:0]);
        if (out_ready) begin
          void'(q_m.pop_front());
        end else begin
          if (stall_m != 16'hFFFF) stall_m++;
          if (stall_s != 3'd7) stall_s++;
        end
      end else begin
        chk("m_out_data_idle", out_data_m, '0);
        chk("s_out_data_idle", out_data_s, '0);
      end

      chk("n_out_valid", out_valid_n, q_n.size() != 0);
      chk("n_in_ready", in_ready_n, (q_n.size() == 0) || out_ready);
      chk("n_stall_cnt", stall_cnt_n, stall_n);
      if (q_n.size() != 0) begin
        chk("n_out_data", out_data_n, q_n[0]);
        if (out_ready) void'(q_n.pop_front());
        else if (stall_n != 16'hFFFF) stall_n++;
      end else begin
        chk("n_out_data_idle", out_data_n, '0);
      end
    end
  end

  initial begin
    logic [159:0] rnd;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;

    // Stream 0x11..0x15 with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 134'(8'h11 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Back-pressure: A accepted, stall starts as B is offered, C held.
    in_valid = 1'b1; in_data = 134'hA; out_ready = 1'b1;
    step();
    in_data = 134'hB; out_ready = 1'b0;
    step();
    in_data = 134'hC;
    chk("n_in_ready_stalled", in_ready_n, 1'b0);
    repeat (10) step();
    out_ready = 1'b1;
    #1 chk("n_in_ready_follows_out_ready", in_ready_n, 1'b1);
    repeat (2) step();
    in_valid = 1'b0;
    repeat (3) step();

    // Flush while FULL with a concurrent offer.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 134'hD1;
    step();
    in_data = 134'hD2;
    step();
    flush = 1'b1; in_data = 134'hD3;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Async reset in the middle of a stall.
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 1'b1; in_data = 134'h5A; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("stall_cnt_before_reset", stall_cnt_m, 16'd5);
    reset = 1'b0;
    #1;
    chk("async_out_valid", out_valid_m, 1'b0);
    chk("async_out_data", out_data_m, '0);
    chk("async_in_ready", in_ready_m, 1'b1);
    chk("async_stall_cnt", stall_cnt_m, '0);
    chk("async_out_valid_n", out_valid_n, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    in_valid = 1'b1; in_data = 134'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rnd       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = rnd[133:0];
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
